// File: rtl/dif_scheduler.sv
// Sample/differentiate/evaluate sequencer for the third-order differentiator path.
// Optional event debounce is enabled by defining DIF_DEBOUNCE_EN.
module dif_scheduler #(
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT    = 16,
  parameter int WARMUP     = 3,
  parameter int DEBOUNCE_N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [12:0] thresh,
  output logic        sample_req,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  output logic        en_third_dif,
  output logic [11:0] current_data,
  input  logic [12:0] third_dif_data,
  input  logic        third_dif_finish,
  output logic [12:0] abs_dif,
  output logic        dif_valid,
  output logic        event_flag,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WARM_INIT = WW'(WARMUP);

  if (SAMPLE_DIV < 8 || TIMEOUT < 1 || DEBOUNCE_N < 1) begin : g_cfg_check
    $error("dif_scheduler: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_PERIOD, S_WAIT_ADC, S_ISSUE, S_WAIT_DONE, S_EVAL
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [11:0] cur_q, cur_d;
  logic [12:0] abs_q, abs_d;
  logic        err_q, err_d;
  logic [12:0] abs_in;
  logic        over;
  logic        wait_expired;

`ifdef DIF_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_N + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_N);
  localparam logic [DW-1:0] DEB_PRE = DW'(DEBOUNCE_N - 1);
  logic [DW-1:0] deb_q, deb_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      warm_q  <= '0;
      cur_q   <= '0;
      abs_q   <= '0;
      err_q   <= 1'b0;
`ifdef DIF_DEBOUNCE_EN
      deb_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      warm_q  <= warm_d;
      cur_q   <= cur_d;
      abs_q   <= abs_d;
      err_q   <= err_d;
`ifdef DIF_DEBOUNCE_EN
      deb_q   <= deb_d;
`endif
    end
  end

  // Two's-complement magnitude; -4096 wraps to 13'h1000 which reads as 4096 unsigned.
  assign abs_in       = third_dif_data[12] ? (~third_dif_data + 13'd1) : third_dif_data;
  assign over         = abs_q > thresh;
  assign wait_expired = (wcnt_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = (state_q == S_IDLE || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    wcnt_d       = wcnt_q;
    warm_d       = warm_q;
    cur_d        = cur_q;
    abs_d        = abs_q;
    err_d        = err_q;
    sample_req   = 1'b0;
    en_third_dif = 1'b0;
    dif_valid    = 1'b0;
    event_flag   = 1'b0;
`ifdef DIF_DEBOUNCE_EN
    deb_d        = deb_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_PERIOD;
          warm_d  = WARM_INIT;
          err_d   = 1'b0;
`ifdef DIF_DEBOUNCE_EN
          deb_d   = '0;
`endif
        end
      end
      S_PERIOD: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          sample_req = 1'b1;
          wcnt_d     = '0;
          state_d    = S_WAIT_ADC;
        end
      end
      S_WAIT_ADC: begin
        if (adc_valid) begin
          cur_d   = adc_data;
          state_d = S_ISSUE;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = S_PERIOD;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        en_third_dif = 1'b1;
        wcnt_d       = '0;
        state_d      = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (third_dif_finish) begin
          abs_d   = abs_in;
          state_d = S_EVAL;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = S_PERIOD;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
      end
      S_EVAL: begin
        // Run is only honoured here and in PERIOD so the differentiator never sees a torn sample.
        state_d = run ? S_PERIOD : S_IDLE;
        if (warm_q != '0) begin
          warm_d = warm_q - 1'b1;
        end else begin
          dif_valid = 1'b1;
`ifdef DIF_DEBOUNCE_EN
          if (over) begin
            if (deb_q != DEB_MAX) deb_d = deb_q + 1'b1;
            event_flag = (deb_q == DEB_PRE);
          end else begin
            deb_d = '0;
          end
`else
          event_flag = over;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign current_data = cur_q;
  assign abs_dif      = abs_q;
  assign timeout_err  = err_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_dif_scheduler.sv
// Directed + randomized bench for dif_scheduler with a transaction-level reference model.
module tb_dif_scheduler;
  localparam int DIV = 8;
  localparam int TO  = 16;
  localparam int WU  = 3;
  localparam int DN  = 4;

  logic        clk = 1'b0;
  logic        rst_n, run, adc_valid, third_dif_finish;
  logic [12:0] thresh, third_dif_data;
  logic [11:0] adc_data;
  logic        sample_req, en_third_dif, dif_valid, event_flag, timeout_err, busy;
  logic [11:0] current_data;
  logic [12:0] abs_dif;

  dif_scheduler #(.SAMPLE_DIV(DIV), .TIMEOUT(TO), .WARMUP(WU), .DEBOUNCE_N(DN)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .thresh(thresh),
    .sample_req(sample_req), .adc_valid(adc_valid), .adc_data(adc_data),
    .en_third_dif(en_third_dif), .current_data(current_data),
    .third_dif_data(third_dif_data), .third_dif_finish(third_dif_finish),
    .abs_dif(abs_dif), .dif_valid(dif_valid), .event_flag(event_flag),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int en_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (en_third_dif === 1'b1) en_cnt++;

  int tests = 0, fails = 0;
  int m_warm = 0, m_deb = 0, n_issue = 0, last_req = -1;
  bit m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic run_start;
    m_warm = WU; m_deb = 0; m_err = 1'b0; last_req = -1;
  endtask

  // Reference: magnitude, warm-up masking, strict compare, optional debounce.
  task automatic model_eval(input logic [12:0] res, input logic [12:0] th,
                            output int a, output bit v, output bit e);
    int r;
    r = res[12] ? int'(res) - 8192 : int'(res);
    a = (r < 0) ? -r : r;
    v = 1'b0; e = 1'b0;
    if (m_warm > 0) begin
      m_warm--;
    end else begin
      v = 1'b1;
`ifdef DIF_DEBOUNCE_EN
      if (a > int'(th)) begin
        if (m_deb < DN) begin
          m_deb++;
          e = (m_deb == DN);
        end
      end else begin
        m_deb = 0;
      end
`else
      e = (a > int'(th));
`endif
    end
  endtask

  // mode: 0 normal, 1 no finish, 2 no adc_valid, 3 reset in WAIT_DONE, 4 drop run in WAIT_ADC
  task automatic do_sample(input logic [12:0] res, input logic [12:0] th, input int mode);
    int k, a, e_seen;
    bit v, e;
    logic [11:0] d;
    k = 0;
    adc_valid = 1'b0; third_dif_finish = 1'b0;
    while (sample_req !== 1'b1 && k < 64) begin
      if ($urandom_range(0, 3) == 0) begin adc_valid = 1'b1; adc_data = 12'($urandom); end
      if ($urandom_range(0, 3) == 0) begin third_dif_finish = 1'b1; third_dif_data = 13'($urandom); end
      tick;
      adc_valid = 1'b0; third_dif_finish = 1'b0;
      k++;
    end
    chk("sample_req_wait", 32'(k < 64), 32'd1);
    if (k >= 64) return;
    if (last_req >= 0) chk("sample_period", 32'((cyc - last_req) % DIV), 32'd0);
    last_req = cyc;
    tick;
    thresh = th;
    chk("sample_req_pulse", 32'(sample_req), 32'd0);
    if (mode == 2) begin
      repeat (15) tick;
      chk("adc_to_early", 32'(timeout_err), 32'(m_err));
      tick;
      chk("adc_to_set", 32'(timeout_err), 32'd1);
      chk("adc_to_no_en", 32'(en_cnt), 32'(n_issue));
      m_err = 1'b1;
      return;
    end
    d = 12'($urandom);
    adc_valid = 1'b1; adc_data = d;
    if (mode == 4) run = 1'b0;
    tick;
    adc_valid = 1'b0;
    chk("en_issue", 32'(en_third_dif), 32'd1);
    chk("current_data_issue", 32'(current_data), 32'(d));
    n_issue++;
    tick;
    chk("en_single", 32'(en_third_dif), 32'd0);
    chk("current_data_hold", 32'(current_data), 32'(d));
    if (mode == 3) begin
      rst_n = 1'b0; run = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outs", {18'd0, sample_req, en_third_dif, dif_valid, event_flag, timeout_err, 1'b0, abs_dif}, 32'd0);
      chk("rst_cur", 32'(current_data), 32'd0);
      m_err = 1'b0;
      e_seen = 0;
      repeat (20) begin tick; if (en_third_dif !== 1'b0 || busy !== 1'b0) e_seen++; end
      chk("rst_stays_idle", 32'(e_seen), 32'd0);
      return;
    end
    if (mode == 1) begin
      repeat (15) tick;
      chk("dif_to_early", 32'(timeout_err), 32'(m_err));
      tick;
      chk("dif_to_set", 32'(timeout_err), 32'd1);
      chk("dif_to_busy", 32'(busy), 32'd1);
      m_err = 1'b1;
      return;
    end
    tick;
    third_dif_finish = 1'b1; third_dif_data = res;
    tick;
    third_dif_finish = 1'b0;
    model_eval(res, th, a, v, e);
    chk("abs_dif", 32'(abs_dif), 32'(a));
    chk("dif_valid", 32'(dif_valid), 32'(v));
    chk("event_flag", 32'(event_flag), 32'(e));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    if (mode == 4) begin
      tick;
      chk("run_drop_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; thresh = 13'd100; adc_valid = 1'b0; adc_data = '0;
    third_dif_finish = 1'b0; third_dif_data = '0;
    tick; tick;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_outs", {18'd0, sample_req, en_third_dif, dif_valid, event_flag, timeout_err, 1'b0, abs_dif}, 32'd0);
    chk("reset_cur", 32'(current_data), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("idle_no_run", 32'(busy), 32'd0);

    run = 1'b1; run_start;
    repeat (4) do_sample(13'($urandom), 13'd100, 0);

    do_sample(13'd200, 13'd100, 0);
    do_sample(13'd200, 13'd100, 0);
    do_sample(13'd50,  13'd100, 0);
    repeat (3) do_sample(13'd200, 13'd100, 0);
    do_sample(13'd50, 13'd100, 0);
    repeat (4) do_sample(13'd200, 13'd100, 0);

    do_sample(13'h1000, 13'd4095, 0);
    do_sample(13'd100,  13'd100,  0);
    do_sample(13'h1F9C, 13'd100,  0);

    repeat (30) do_sample(13'($urandom), 13'($urandom_range(0, 4096)), 0);

    do_sample(13'd10, 13'd100, 1);
    do_sample(13'd300, 13'd100, 0);
    do_sample(13'd10, 13'd100, 2);
    do_sample(13'd300, 13'd100, 0);
    run = 1'b0;
    tick;
    chk("toggle_idle", 32'(busy), 32'd0);
    chk("toggle_err_sticky", 32'(timeout_err), 32'd1);
    run = 1'b1; run_start;
    tick;
    chk("toggle_err_clear", 32'(timeout_err), 32'd0);
    chk("toggle_busy", 32'(busy), 32'd1);

    do_sample(13'd200, 13'd100, 4);
    run = 1'b1; run_start;
    repeat (4) do_sample(13'd200, 13'd100, 0);

    do_sample(13'd200, 13'd100, 3);
    run = 1'b1; run_start;
    repeat (5) do_sample(13'($urandom), 13'($urandom_range(0, 4096)), 0);

    chk("en_count", 32'(en_cnt), 32'(n_issue));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dif_scheduler.md
Name: dif_scheduler

Overview:
Sequencer for the third-order differentiator in the neck-check signal path.
- Paces ADC sampling and requests a conversion every sample period.
- Hands each 12-bit sample to the differentiator with a one-cycle enable pulse, then waits for its finish flag.
- Takes the absolute value of the result, masks warm-up results, compares against a threshold and raises an event flag that downstream posture/alarm logic consumes.

Parameters:
SAMPLE_DIV, 1000, clocks per sample period (≥8).
TIMEOUT, 16, max clocks to wait for adc_valid or third_dif_finish before error.
WARMUP, 3, differentiator results discarded after each run start.
DEBOUNCE_N, 4, consecutive over-threshold results needed for an event (only with DIF_DEBOUNCE_EN).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
run  in  1  level; 1 = scheduling enabled
thresh  in  13  unsigned event threshold
sample_req  out  1  one-cycle pulse to ADC controller
adc_valid  in  1  one-cycle pulse, adc_data valid
adc_data  in  12  ADC sample
en_third_dif  out  1  one-cycle enable pulse to differentiator
current_data  out  12  sample presented to differentiator
third_dif_data  in  13  signed differentiator result
third_dif_finish  in  1  one-cycle completion pulse
abs_dif  out  13  unsigned |third_dif_data| of last evaluated result
dif_valid  out  1  one-cycle pulse, abs_dif updated (post-warm-up only)
event_flag  out  1  one-cycle pulse, threshold event
timeout_err  out  1  sticky error, cleared by reset or run rising edge
busy  out  1  1 in any state except IDLE

Behaviour:
- Reset: rst_n sampled low at a clk edge sets every output to 0, state IDLE, and clears all counters. It applies from any state.
- States:
  - IDLE: wait for run=1. On entry the period counter is cleared.
  - PERIOD: count to SAMPLE_DIV-1, then pulse sample_req and go to WAIT_ADC.
  - WAIT_ADC: on adc_valid, latch adc_data into current_data and go to ISSUE.
  - ISSUE: en_third_dif=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: on third_dif_finish, register abs_dif and go to EVAL.
  - EVAL: apply the warm-up mask, threshold compare and event logic, then go to PERIOD.
- Timing:
  - The period counter runs continuously through all non-IDLE states. The sample period is therefore exactly SAMPLE_DIV clocks, independent of ADC and differentiator latency.
  - Nominal differentiator latency is 2 clocks from the en_third_dif cycle to third_dif_finish.
  - current_data is held stable from ISSUE until the next adc_valid latch.
- Run edge: a run rising edge (IDLE→PERIOD) reloads the warm-up counter to WARMUP and clears timeout_err and the debounce count. The differentiator history is stale after a stop, which is why warm-up reapplies on every start.
- Run low: deasserting run returns to IDLE only from PERIOD or EVAL. An in-flight conversion/differentiation always completes so the differentiator's state and history stay consistent.
- Warm-up: while the warm-up counter is non-zero, EVAL decrements it and suppresses dif_valid and event_flag. abs_dif still updates.
- Abs: abs_dif = third_dif_data<0 ? -third_dif_data : third_dif_data, computed 13-bit unsigned. -4096 maps to 4096 with no saturation needed.
- Compare: over = abs_dif > thresh (strict). abs_dif == thresh is not over.
- Timeout: WAIT_ADC or WAIT_DONE exceeding TIMEOUT clocks sets timeout_err and returns to PERIOD. Stray adc_valid/third_dif_finish pulses outside their wait states are ignored.
- Simultaneous events: if the period counter wraps while still in WAIT_ADC/WAIT_DONE/ISSUE/EVAL, the sample is skipped (no sample_req) and the counter keeps running.

Optional Feature:
DIF_DEBOUNCE_EN
- Defined: a saturating counter (width clog2(DEBOUNCE_N+1)) increments on each post-warm-up over result and clears on not-over. event_flag pulses once, in the EVAL cycle where the count reaches DEBOUNCE_N. No further events occur until a not-over result clears the counter.
- Not defined: event_flag pulses in every post-warm-up EVAL with over=1. DEBOUNCE_N is unused.

Test Plan:
1. Reset mid-WAIT_DONE (rst_n low one edge) → next cycle all outputs 0, state IDLE, busy=0; no en_third_dif until run is reasserted.
2. SAMPLE_DIV=8, run=1, ADC answers 1 clk after sample_req, model differentiator with 2-clk latency → sample_req every 8 clks; exactly one en_third_dif per sample; first 3 results give no dif_valid; the 4th gives dif_valid.
3. Differentiator result -4096, thresh=4095 → abs_dif=4096, event_flag=1. Result +100 with thresh=100 → no event.
4. Debounce off: results 200,200,50 with thresh=100 post-warm-up → event_flag on the first two only. Debounce on (DEBOUNCE_N=4): 200×3, 50, 200×4 → single event on the 8th result.
5. Withhold third_dif_finish, TIMEOUT=16 → timeout_err set 16 clks after the ISSUE cycle, state returns to PERIOD, next sample proceeds. Run toggle 1→0→1 clears timeout_err.
6. Deassert run during WAIT_ADC → that sample still completes through EVAL, then IDLE. Reassert run → warm-up reapplies: 3 suppressed results.
